sensor_alarm_ctrl: RTL
======================

# sensor_alarm_ctrl

Parametrised N-sensor intrusion alarm controller: debounces N asynchronous sensor inputs, arms/disarms on command, raises a timed, re-triggerable alarm when at least MIN_ACTIVE sensors are active, and drives LED, pulsed buzzer and a common-anode 7-segment digit. It is the next-generation replacement for the fixed two-sensor alarm FSM on the board top level and adds acknowledge, cooldown and an event counter.

## Interface
- N_SENSORS, 4: number of sensor channels, 1..15
- MIN_ACTIVE, 2: debounced-active sensors required to trigger, 1..N_SENSORS
- DEBOUNCE_CYCLES, 500_000: cycles a synchronised input must differ from its debounced value before the debounced value flips, ≥1
- ALARM_CYCLES, 50_000_000: alarm period length in cycles, ≥2
- COOLDOWN_CYCLES, 100_000_000: post-alarm trigger-ignore window in cycles, ≥1
- BEEP_HALF_CYCLES, 12_500_000: buzzer half-period in cycles, ≥1

- clk  in  1  system clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- sensor  in  N_SENSORS  raw asynchronous sensor inputs, active-high
- arm  in  1  level: 1 = armed, 0 = disarm (synchronous to clk)
- ack  in  1  single-cycle alarm acknowledge pulse (synchronous to clk)
- led  out  1  alarm indicator
- buzzer  out  1  buzzer drive
- seg7  out  7  active-low segments, bit6..bit0 = a..g
- alarm_events  out  8  number of alarm entries from ARMED, saturating at 255

## Operation
- Input path per channel: 2-FF synchroniser, then debounce counter. Counter clears whenever synchronised value equals debounced value; otherwise it increments; on the edge where it would reach DEBOUNCE_CYCLES, the debounced bit takes the synchronised value and the counter clears.
- active_cnt = popcount(debounced); trigger = (active_cnt ≥ MIN_ACTIVE).
- FSM states DISARMED, ARMED, ALARM, COOLDOWN. Priority within each state: arm=0 first, then ack, then timer/trigger.
  - DISARMED: arm=1 → ARMED.
  - ARMED: arm=0 → DISARMED; trigger → ALARM, timer=0, alarm_events +1 (saturating).
  - ALARM: arm=0 → DISARMED; ack → COOLDOWN; timer == ALARM_CYCLES-1: trigger → stay ALARM with timer=0 (re-arm of period, no event increment), else → COOLDOWN. Otherwise timer +1.
  - COOLDOWN: triggers ignored; arm=0 → DISARMED; timer == COOLDOWN_CYCLES-1 → ARMED; ack ignored.
- Timer cleared on every state entry. One shared timer, width ceil(log2(max(ALARM_CYCLES, COOLDOWN_CYCLES))).
- Buzzer: 1 only in ALARM; beep phase register set to 1 and beep counter cleared on every ALARM entry (including period re-arm); phase toggles each BEEP_HALF_CYCLES cycles.
- led = 1 in ALARM; in COOLDOWN led = beep phase-independent constant 0; else 0.
- seg7: DISARMED → blank 7'b1111111; other states → digit min(active_cnt, 9), active-low patterns 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.

## Timing
- Reset: state DISARMED, timer 0, all debounced bits 0, synchronisers 0, debounce counters 0, alarm_events 0, led 0, buzzer 0, seg7 7'b1111111.
- Reset mid-alarm returns all of the above on the next edge; alarm_events is cleared only by rst.
- led, buzzer: Moore decode of registered state/phase, no extra latency after the state edge.
- seg7: registered, one cycle after state/active_cnt.
- Raw sensor step (held stable) → debounced change 2 + DEBOUNCE_CYCLES edges later; ARMED→ALARM one further edge.
- Glitch shorter than DEBOUNCE_CYCLES synchronised cycles: no debounced change.
- ALARM lasts exactly ALARM_CYCLES cycles absent ack/disarm; COOLDOWN exactly COOLDOWN_CYCLES.
- ack and trigger on the same ARMED cycle: ack ignored (only meaningful in ALARM).
- ack on the ALARM timeout cycle: ack wins → COOLDOWN.

## Test plan
Params N_SENSORS=4, MIN_ACTIVE=2, DEBOUNCE_CYCLES=4, ALARM_CYCLES=20, COOLDOWN_CYCLES=10, BEEP_HALF_CYCLES=3.
- Reset then arm=1, sensor=4'b0011 held → ALARM entered 7 edges after sensor change; led=1, buzzer pattern 1,1,1,0,0,0,…; alarm_events=1; seg7=0010010.
- Sensor pulses of 3 cycles on two channels while ARMED → no debounced change, stays ARMED, alarm_events=0.
- Sensors held active through timeout → ALARM period restarts at cycle 20, buzzer phase restarts at 1, alarm_events stays 1; release sensors → COOLDOWN after next 20 cycles, then ARMED after 10.
- ack during ALARM → COOLDOWN next edge, led=0, buzzer=0; sensors active during COOLDOWN → no re-alarm until ARMED, then ALARM with alarm_events=2.
- arm=0 mid-ALARM → DISARMED, seg7 blank, outputs 0; rst mid-ALARM → all reset values including alarm_events=0.
- 256 alarm entries → alarm_events saturates at 255; sensor=4'b1111 → seg7 digit 4 (1001100).

Source files
------------

// File: rtl/sensor_alarm_ctrl.sv
// N-sensor intrusion alarm: synchronised, debounced inputs feed an armed/alarm/cooldown FSM
// that drives the LED, a pulsed buzzer and a registered 7-segment digit.
module sensor_alarm_ctrl #(
  parameter int N_SENSORS        = 4,
  parameter int MIN_ACTIVE       = 2,
  parameter int DEBOUNCE_CYCLES  = 500_000,
  parameter int ALARM_CYCLES     = 50_000_000,
  parameter int COOLDOWN_CYCLES  = 100_000_000,
  parameter int BEEP_HALF_CYCLES = 12_500_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SENSORS-1:0] sensor,
  input  logic                 arm,
  input  logic                 ack,
  output logic                 led,
  output logic                 buzzer,
  output logic [6:0]           seg7,
  output logic [7:0]           alarm_events
);

  // state      | meaning
  // DISARMED   | idle, display blank, triggers ignored
  // ARMED      | watching for MIN_ACTIVE debounced sensors
  // ALARM      | led on, buzzer pulsing, timed period
  // COOLDOWN   | post-alarm window, triggers and ack ignored
  typedef enum logic [1:0] {S_DISARMED, S_ARMED, S_ALARM, S_COOLDOWN} state_t;

  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMR_MAX = (ALARM_CYCLES > COOLDOWN_CYCLES) ? ALARM_CYCLES : COOLDOWN_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam int BEEP_W  = (BEEP_HALF_CYCLES > 1) ? $clog2(BEEP_HALF_CYCLES) : 1;

  logic [N_SENSORS-1:0] sync1, sync2, deb;
  logic [DB_W-1:0]      db_cnt [N_SENSORS];
  logic [3:0]           active_cnt;
  logic                 trigger;

  state_t               state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 alarm_start, event_inc;
  logic                 phase_q;
  logic [BEEP_W-1:0]    beep_cnt_q;
  logic [6:0]           seg_q, seg_d;
  logic [7:0]           events_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < N_SENSORS; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= sensor;
      sync2 <= sync1;
      for (int i = 0; i < N_SENSORS; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  always_comb begin
    active_cnt = '0;
    for (int i = 0; i < N_SENSORS; i++) active_cnt = active_cnt + 4'(deb[i]);
  end

  assign trigger = (active_cnt >= 4'(MIN_ACTIVE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_DISARMED;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    alarm_start = 1'b0;
    event_inc   = 1'b0;
    case (state_q)
      S_DISARMED: begin
        if (arm) begin
          state_d = S_ARMED;
          timer_d = '0;
        end
      end
      S_ARMED: begin
        if (!arm) begin
          state_d = S_DISARMED;
          timer_d = '0;
        end else if (trigger) begin
          state_d     = S_ALARM;
          timer_d     = '0;
          alarm_start = 1'b1;
          event_inc   = 1'b1;
        end
      end
      S_ALARM: begin
        if (!arm) begin
          state_d = S_DISARMED;
          timer_d = '0;
        end else if (ack) begin
          state_d = S_COOLDOWN;
          timer_d = '0;
        end else if (timer_q == TMR_W'(ALARM_CYCLES - 1)) begin
          // A still-present trigger restarts the period without counting a new event
          timer_d = '0;
          if (trigger) alarm_start = 1'b1;
          else         state_d     = S_COOLDOWN;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_COOLDOWN: begin
        if (!arm) begin
          state_d = S_DISARMED;
          timer_d = '0;
        end else if (timer_q == TMR_W'(COOLDOWN_CYCLES - 1)) begin
          state_d = S_ARMED;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = S_DISARMED;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= 1'b0;
      beep_cnt_q <= '0;
    end else if (alarm_start) begin
      phase_q    <= 1'b1;
      beep_cnt_q <= '0;
    end else if (state_q == S_ALARM) begin
      if (beep_cnt_q == BEEP_W'(BEEP_HALF_CYCLES - 1)) begin
        phase_q    <= ~phase_q;
        beep_cnt_q <= '0;
      end else begin
        beep_cnt_q <= beep_cnt_q + BEEP_W'(1);
      end
    end else begin
      phase_q    <= 1'b0;
      beep_cnt_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                               events_q <= '0;
    else if (event_inc && events_q != 8'hFF) events_q <= events_q + 8'd1;
  end

  always_comb begin
    seg_d = 7'b1111111;
    if (state_q != S_DISARMED) begin
      case ((active_cnt > 4'd9) ? 4'd9 : active_cnt)
        4'd0:    seg_d = 7'b0000001;
        4'd1:    seg_d = 7'b1001111;
        4'd2:    seg_d = 7'b0010010;
        4'd3:    seg_d = 7'b0000110;
        4'd4:    seg_d = 7'b1001100;
        4'd5:    seg_d = 7'b0100100;
        4'd6:    seg_d = 7'b0100000;
        4'd7:    seg_d = 7'b0001111;
        4'd8:    seg_d = 7'b0000000;
        default: seg_d = 7'b0000100;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) seg_q <= 7'b1111111;
    else     seg_q <= seg_d;
  end

  assign led          = (state_q == S_ALARM);
  assign buzzer       = (state_q == S_ALARM) && phase_q;
  assign seg7         = seg_q;
  assign alarm_events = events_q;

endmodule
